fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 6 +
 rtl/fetch_unit_if.sv | 9 +
 rtl/fetch_out_reg.sv | 28 ++
 rtl/fetch_unit.sv | 58 +++++
 tb/tb_fetch_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants and FSM encoding for the fetch unit
package fetch_unit_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
    typedef enum logic {RUN, FAULT} state_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-to-decode valid/ready beat channel
interface fetch_unit_if;
    logic out_valid;
    logic out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    modport master(output out_valid, out_pc, out_instr, input out_ready);
    modport slave(input out_valid, out_pc, out_instr, output out_ready);
endinterface

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: output beat register holding pc/instr until decode accepts
module fetch_out_reg import fetch_unit_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        ready,
    input  logic [31:0] ld_pc,
    input  logic [31:0] ld_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);
    // pc/instr only move on load, so a flushed beat leaves the last values visible
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc <= 32'h0;
            instr <= INSTR_NOP;
        end else begin
            valid <= flush ? 1'b0 : load ? 1'b1 : ready ? 1'b0 : valid;
            if (load) begin
                pc <= ld_pc;
                instr <= ld_instr;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, redirect/fault FSM and accepted-beat counter
module fetch_unit import fetch_unit_pkg::*; #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_data,
    fetch_unit_if.master          out,
    output logic                  fault,
    output logic [31:0]           fetch_count
);
    state_t state, state_n;
    logic [31:0] pc, pc_n;
    logic load;
    assign rom_addr = pc[ADDR_WIDTH+1:2];
    assign fault = state == FAULT;
    always_comb begin
        state_n = state;
        pc_n = pc;
        load = 1'b0;
        if (redirect_valid) begin
            pc_n = redirect_pc;
            state_n = redirect_pc[1:0] == 2'b00 ? RUN : FAULT;
        end else if (state == RUN && fetch_en && (!out.out_valid || out.out_ready)) begin
            load = 1'b1;
            pc_n = pc + 32'd4;
        end
    end
    // an accepted beat counts even when a redirect flushes it in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc <= RESET_PC;
            fetch_count <= 32'h0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            fetch_count <= fetch_count + 32'(out.out_valid && out.out_ready);
        end
    end
    fetch_out_reg u_out (
        .clk(clk),
        .rst(rst),
        .load(load),
        .flush(redirect_valid),
        .ready(out.out_ready),
        .ld_pc(pc),
        .ld_instr(rom_data),
        .valid(out.out_valid),
        .pc(out.out_pc),
        .instr(out.out_instr)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit
module tb_fetch_unit;
    import fetch_unit_pkg::*;
    logic clk = 1'b0;
    logic rst, fetch_en, redirect_valid;
    logic [31:0] redirect_pc, rom_data, fetch_count;
    logic [15:0] rom_addr;
    logic fault;
    int vectors = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    fetch_unit_if bus();
    fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .fetch_en(fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .out(bus),
        .fault(fault),
        .fetch_count(fetch_count)
    );
    always #5 clk = ~clk;
    assign rom_data = 32'hA000_0000 | 32'(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat_pc", bus.out_pc, 32'hDEAD_BEEF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("beat_pc", bus.out_pc, e[63:32]);
                check("beat_instr", bus.out_instr, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        bus.out_ready = 1'b0;
        step(2);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_instr", bus.out_instr, 32'h0000_0013);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        // straight-line stream of four beats
        exp_q.push_back({32'h0, 32'hA000_0000});
        exp_q.push_back({32'h4, 32'hA000_0001});
        exp_q.push_back({32'h8, 32'hA000_0002});
        exp_q.push_back({32'hC, 32'hA000_0003});
        rst = 1'b0;
        fetch_en = 1'b1;
        bus.out_ready = 1'b1;
        step(1);
        check("first_beat_pc", bus.out_pc, 32'h0);
        step(3);
        fetch_en = 1'b0;
        step(1);
        check("stream_count", fetch_count, 32'd4);
        check("stream_idle", 32'(bus.out_valid), 32'd0);
        // backpressure on beat (8,A2)
        rst = 1'b1;
        step(1);
        exp_q.push_back({32'h0, 32'hA000_0000});
        exp_q.push_back({32'h4, 32'hA000_0001});
        rst = 1'b0;
        fetch_en = 1'b1;
        step(3);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_pc", bus.out_pc, 32'h8);
            check("hold_instr", bus.out_instr, 32'hA000_0002);
            check("hold_rom_addr", 32'(rom_addr), 32'd3);
        end
        exp_q.push_back({32'h8, 32'hA000_0002});
        exp_q.push_back({32'hC, 32'hA000_0003});
        bus.out_ready = 1'b1;
        step(1);
        fetch_en = 1'b0;
        step(1);
        check("hold_count", fetch_count, 32'd4);
        // redirect while (4,A1) is held
        rst = 1'b1;
        step(1);
        exp_q.push_back({32'h0, 32'hA000_0000});
        rst = 1'b0;
        fetch_en = 1'b1;
        step(2);
        bus.out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        check("redir_flush_valid", 32'(bus.out_valid), 32'd0);
        check("redir_count", fetch_count, 32'd1);
        exp_q.push_back({32'h100, 32'hA000_0040});
        bus.out_ready = 1'b1;
        step(1);
        check("redir_beat_pc", bus.out_pc, 32'h100);
        fetch_en = 1'b0;
        step(1);
        // misaligned redirect parks in FAULT
        fetch_en = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        step(1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("fault_flag", 32'(fault), 32'd1);
            check("fault_valid", 32'(bus.out_valid), 32'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step(1);
        check("fault_clear", 32'(fault), 32'd0);
        exp_q.push_back({32'h200, 32'hA000_0080});
        redirect_valid = 1'b0;
        step(1);
        // accept (0x200) in the same cycle as a redirect to 0x300
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        step(1);
        redirect_valid = 1'b0;
        check("redir_accept_count", fetch_count, 32'd3);
        check("redir_accept_flush", 32'(bus.out_valid), 32'd0);
        exp_q.push_back({32'h300, 32'hA000_00C0});
        step(1);
        fetch_en = 1'b0;
        step(1);
        check("count_after_300", fetch_count, 32'd4);
        // reset with a held beat
        fetch_en = 1'b1;
        bus.out_ready = 1'b0;
        step(1);
        check("pre_rst_held", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        step(1);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_count", fetch_count, 32'd0);
        check("midrst_instr", bus.out_instr, 32'h0000_0013);
        exp_q.push_back({32'h0, 32'hA000_0000});
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step(1);
        check("postrst_pc", bus.out_pc, 32'h0);
        fetch_en = 1'b0;
        step(1);
        // ROM address aliasing across the 16-bit word boundary
        redirect_valid = 1'b1;
        redirect_pc = 32'h0003_FFFC;
        step(1);
        redirect_valid = 1'b0;
        check("alias_top", 32'(rom_addr), 32'h0000_FFFF);
        exp_q.push_back({32'h0003_FFFC, 32'hA000_FFFF});
        exp_q.push_back({32'h0004_0000, 32'hA000_0000});
        fetch_en = 1'b1;
        step(1);
        check("alias_wrap", 32'(rom_addr), 32'h0);
        step(1);
        fetch_en = 1'b0;
        step(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
